// File: rtl/rv_timer_nch.sv
// rv_timer_nch: multi-channel machine timer on the single-cycle req/rvalid bus.
// One shared 64-bit mtime with prescaler, NumChannels 64-bit comparators with
// interrupt enable, sticky pending and optional periodic reload.
// Build option: define RV_TIMER_NCH_SNAPSHOT_EN to make a MTIME_LO read latch
// mtime[63:32] so a following MTIME_HI read returns a coherent 64-bit value.
module rv_timer_nch #(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned NumChannels   = 4,
    parameter int unsigned PrescaleWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    timer_req_i,
    input  logic [AddressWidth-1:0] timer_addr_i,
    input  logic                    timer_we_i,
    input  logic [DataWidth/8-1:0]  timer_be_i,
    input  logic [DataWidth-1:0]    timer_wdata_i,
    output logic                    timer_rvalid_o,
    output logic [DataWidth-1:0]    timer_rdata_o,
    output logic                    timer_err_o,
    output logic [NumChannels-1:0]  timer_intr_o
);

    if (DataWidth != 32) begin : g_bad_data_width
        $error("rv_timer_nch: DataWidth must be 32");
    end
    if (NumChannels < 1 || NumChannels > 16) begin : g_bad_num_channels
        $error("rv_timer_nch: NumChannels must be within 1..16");
    end

    // only the 64 KiB window offset is decoded
    logic unused_addr_bits;
    assign unused_addr_bits = ^timer_addr_i[AddressWidth-1:16];

    logic [15:0] off;
    logic [31:0] wdata;
    logic [9:0]  ch_idx;
    logic [1:0]  ch_fld;
    logic        wr_en, rd_en;
    logic        is_ctrl, is_psc, is_mlo, is_mhi, is_chan_region, is_chan;
    logic [NumChannels-1:0] ch_sel;

    assign off     = timer_addr_i[15:0];
    assign wdata   = timer_wdata_i[31:0];
    assign ch_idx  = off[13:4];
    assign ch_fld  = off[3:2];
    assign wr_en   = timer_req_i & timer_we_i & (&timer_be_i);
    assign rd_en   = timer_req_i & ~timer_we_i;
    assign is_ctrl = (off == 16'h0000);
    assign is_psc  = (off == 16'h0004);
    assign is_mlo  = (off == 16'h4000);
    assign is_mhi  = (off == 16'h4004);
    assign is_chan_region = (off[15:14] == 2'b10) && (off[1:0] == 2'b00);
    assign is_chan = |ch_sel;

    // channel select; indices at or above NumChannels select nothing
    always_comb begin
        ch_sel = '0;
        for (int c = 0; c < NumChannels; c++) begin
            ch_sel[c] = is_chan_region && (ch_idx == 10'(c));
        end
    end

    logic                     en_q, en_d;
    logic [PrescaleWidth-1:0] prescale_q, prescale_d;
    logic [PrescaleWidth-1:0] psc_cnt_q, psc_cnt_d;
    logic [63:0]              mtime_q, mtime_d;
    logic                     tick;

    assign tick = en_q && (psc_cnt_q == prescale_q);

    // control, prescaler and mtime next state; a bus write to a mtime half
    // overrides only that half of the increment
    always_comb begin
        en_d       = en_q;
        prescale_d = prescale_q;
        psc_cnt_d  = psc_cnt_q;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        if (en_q) begin
            psc_cnt_d = tick ? '0 : psc_cnt_q + 1'b1;
        end
        if (wr_en && is_ctrl) begin
            en_d = wdata[0];
        end
        if (wr_en && is_psc) begin
            prescale_d = wdata[PrescaleWidth-1:0];
            psc_cnt_d  = '0;
        end
        if (wr_en && is_mlo) begin
            mtime_d[31:0] = wdata;
        end
        if (wr_en && is_mhi) begin
            mtime_d[63:32] = wdata;
        end
    end

    // timer core registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q       <= 1'b0;
            prescale_q <= '0;
            psc_cnt_q  <= '0;
            mtime_q    <= '0;
        end else begin
            en_q       <= en_d;
            prescale_q <= prescale_d;
            psc_cnt_q  <= psc_cnt_d;
            mtime_q    <= mtime_d;
        end
    end

    logic [63:0]            cmp_q [NumChannels];
    logic [63:0]            cmp_d [NumChannels];
    logic [31:0]            period_q [NumChannels];
    logic [31:0]            period_d [NumChannels];
    logic [NumChannels-1:0] ie_q, ie_d;
    logic [NumChannels-1:0] periodic_q, periodic_d;
    logic [NumChannels-1:0] pending_q, pending_d;
    logic [NumChannels-1:0] intr_q, intr_d;
    logic [NumChannels-1:0] match;

    // per-channel compare; a CMP write beats a match, a match beats W1C
    always_comb begin
        ie_d       = ie_q;
        periodic_d = periodic_q;
        pending_d  = pending_q;
        match      = '0;
        for (int c = 0; c < NumChannels; c++) begin
            cmp_d[c]    = cmp_q[c];
            period_d[c] = period_q[c];
            match[c]    = (mtime_q >= cmp_q[c]);
            if (wr_en && ch_sel[c] && (ch_fld == 2'd0 || ch_fld == 2'd1)) begin
                if (ch_fld == 2'd0) begin
                    cmp_d[c][31:0] = wdata;
                end else begin
                    cmp_d[c][63:32] = wdata;
                end
                pending_d[c] = 1'b0;
            end else if (match[c]) begin
                pending_d[c] = 1'b1;
                if (periodic_q[c]) begin
                    cmp_d[c] = cmp_q[c] + {32'd0, period_q[c]};
                end
            end else if (wr_en && ch_sel[c] && ch_fld == 2'd2 && wdata[2]) begin
                pending_d[c] = 1'b0;
            end
            if (wr_en && ch_sel[c] && ch_fld == 2'd2) begin
                ie_d[c]       = wdata[0];
                periodic_d[c] = wdata[1];
            end
            if (wr_en && ch_sel[c] && ch_fld == 2'd3) begin
                period_d[c] = wdata;
            end
        end
        intr_d = pending_d & ie_d;
    end

    // channel registers and registered interrupt lines
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NumChannels; c++) begin
                cmp_q[c]    <= '0;
                period_q[c] <= '0;
            end
            ie_q       <= '0;
            periodic_q <= '0;
            pending_q  <= '0;
            intr_q     <= '0;
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                cmp_q[c]    <= cmp_d[c];
                period_q[c] <= period_d[c];
            end
            ie_q       <= ie_d;
            periodic_q <= periodic_d;
            pending_q  <= pending_d;
            intr_q     <= intr_d;
        end
    end

`ifdef RV_TIMER_NCH_SNAPSHOT_EN
    logic [31:0] shadow_q, shadow_d;

    // MTIME_LO read captures the upper half for a coherent MTIME_HI read
    always_comb begin
        shadow_d = shadow_q;
        if (rd_en && is_mlo) begin
            shadow_d = mtime_q[63:32];
        end
    end

    // snapshot register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`endif

    logic [31:0] rdata_d;
    logic        err_d;
    logic        rvalid_q;
    logic [DataWidth-1:0] rdata_q;
    logic        err_q;

    // read mux; unmapped offsets answer err with zero data
    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (is_ctrl) begin
            rdata_d = {31'd0, en_q};
        end else if (is_psc) begin
            rdata_d = 32'(prescale_q);
        end else if (is_mlo) begin
            rdata_d = mtime_q[31:0];
        end else if (is_mhi) begin
`ifdef RV_TIMER_NCH_SNAPSHOT_EN
            rdata_d = shadow_q;
`else
            rdata_d = mtime_q[63:32];
`endif
        end else if (is_chan) begin
            for (int c = 0; c < NumChannels; c++) begin
                if (ch_sel[c]) begin
                    case (ch_fld)
                        2'd0:    rdata_d = cmp_q[c][31:0];
                        2'd1:    rdata_d = cmp_q[c][63:32];
                        2'd2:    rdata_d = {29'd0, pending_q[c], periodic_q[c], ie_q[c]};
                        default: rdata_d = period_q[c];
                    endcase
                end
            end
        end else begin
            err_d = 1'b1;
        end
    end

    // response valid one cycle after every request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= timer_req_i;
        end
    end

    // response payload, meaningful only while rvalid is high
    always_ff @(posedge clk_i) begin
        if (timer_req_i) begin
            rdata_q <= DataWidth'(rdata_d);
            err_q   <= err_d;
        end
    end

    assign timer_rvalid_o = rvalid_q;
    assign timer_rdata_o  = rdata_q;
    assign timer_err_o    = err_q & rvalid_q;
    assign timer_intr_o   = intr_q;

endmodule

// File: tb/tb_rv_timer_nch.sv
module tb_rv_timer_nch;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  intr;

    int checks = 0;
    int errors = 0;

    rv_timer_nch #(
        .DataWidth(32), .AddressWidth(32), .NumChannels(4), .PrescaleWidth(16)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .timer_req_i    (req),
        .timer_addr_i   (addr),
        .timer_we_i     (we),
        .timer_be_i     (be),
        .timer_wdata_i  (wdata),
        .timer_rvalid_o (rvalid),
        .timer_rdata_o  (rdata),
        .timer_err_o    (err),
        .timer_intr_o   (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    localparam logic [31:0] A_CTRL = 32'h0000, A_PSC = 32'h0004;
    localparam logic [31:0] A_MLO = 32'h4000, A_MHI = 32'h4004;

    function automatic logic [31:0] ch_addr(input int c, input int fld);
        return 32'h8000 + 32'(16 * c) + 32'(4 * fld);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one bus transaction; caller sits on a negedge, returns on the next one
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] rd, output logic er);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        chk("rvalid", {63'd0, rvalid}, 64'd1);
        rd = rdata;
        er = err;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic        er;
        bus(1'b1, a, d, 4'hF, rd, er);
        chk("write err", {63'd0, er}, 64'd0);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        er;
        bus(1'b0, a, 32'd0, 4'hF, rd, er);
        chk(name, {32'd0, rd}, {32'd0, exp});
        chk({name, " err"}, {63'd0, er}, 64'd0);
    endtask

    typedef struct {
        string       name;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] b,
                                input logic cr, input logic [31:0] er, input logic ee);
        vec_t v;
        v.name = n; v.w = w; v.a = a; v.d = d; v.b = b;
        v.chk_rd = cr; v.exp_rd = er; v.exp_err = ee;
        return v;
    endfunction

    logic [31:0] exp_hi;

    initial begin
        logic [31:0] rd_v;
        logic        er_v;

        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        repeat (3) @(negedge clk);
        chk("reset rvalid", {63'd0, rvalid}, 64'd0);
        chk("reset intr", {60'd0, intr}, 64'd0);
        chk("reset err", {63'd0, err}, 64'd0);
        rst_n = 1'b1;

        // count at prescale 0: ten ticks after enable
        wr(A_CTRL, 32'd1);
        repeat (10) @(negedge clk);
        rd_chk("mtime psc0", A_MLO, 32'd10);

        // prescale 3: one tick per four cycles, then freeze
        wr(A_CTRL, 32'd0);
        wr(A_MLO, 32'd0);
        wr(A_MHI, 32'd0);
        wr(A_PSC, 32'd3);
        wr(A_CTRL, 32'd1);
        repeat (40) @(negedge clk);
        rd_chk("mtime psc3", A_MLO, 32'd10);
        wr(A_CTRL, 32'd0);
        rd_chk("mtime frozen a", A_MLO, 32'd10);
        repeat (20) @(negedge clk);
        rd_chk("mtime frozen b", A_MLO, 32'd10);

        // channel 0 one-shot at 100
        wr(A_PSC, 32'd0);
        wr(A_MLO, 32'd90);
        wr(A_MHI, 32'd0);
        wr(ch_addr(0, 0), 32'd100);
        wr(ch_addr(0, 1), 32'd0);
        wr(ch_addr(0, 2), 32'd1);
        wr(A_CTRL, 32'd1);
        repeat (10) @(negedge clk);
        chk("ch0 intr before", {63'd0, intr[0]}, 64'd0);
        @(negedge clk);
        chk("ch0 intr rise", {63'd0, intr[0]}, 64'd1);
        repeat (5) @(negedge clk);
        chk("ch0 intr sticky", {63'd0, intr[0]}, 64'd1);
        rd_chk("ch0 ctrl", ch_addr(0, 2), 32'd5);
        wr(ch_addr(0, 0), 32'd500);
        chk("ch0 intr cleared", {63'd0, intr[0]}, 64'd0);
        repeat (3) @(negedge clk);
        chk("ch0 intr stays low", {63'd0, intr[0]}, 64'd0);
        wr(A_CTRL, 32'd0);

        // register vectors, counter stopped
        vecs.push_back(mk("psc write",        1, A_PSC, 32'h0001ABCD, 4'hF, 0, 32'h0, 0));
        vecs.push_back(mk("psc read",         0, A_PSC, 32'h0, 4'hF, 1, 32'h0000ABCD, 0));
        vecs.push_back(mk("psc high addr",    0, 32'h0001_0004, 32'h0, 4'hF, 1, 32'h0000ABCD, 0));
        vecs.push_back(mk("mlo write",        1, A_MLO, 32'h12345678, 4'hF, 0, 32'h0, 0));
        vecs.push_back(mk("mhi write",        1, A_MHI, 32'h9ABCDEF0, 4'hF, 0, 32'h0, 0));
        vecs.push_back(mk("mlo read",         0, A_MLO, 32'h0, 4'hF, 1, 32'h12345678, 0));
        vecs.push_back(mk("mhi read",         0, A_MHI, 32'h0, 4'hF, 1, 32'h9ABCDEF0, 0));
        vecs.push_back(mk("ctrl partial wr",  1, A_CTRL, 32'h1, 4'h1, 0, 32'h0, 0));
        vecs.push_back(mk("ctrl unchanged",   0, A_CTRL, 32'h0, 4'hF, 1, 32'h0, 0));
        vecs.push_back(mk("cmp0 partial wr",  1, ch_addr(0, 0), 32'h0000FFFF, 4'h3, 0, 32'h0, 0));
        vecs.push_back(mk("cmp0 unchanged",   0, ch_addr(0, 0), 32'h0, 4'hF, 1, 32'd500, 0));
        vecs.push_back(mk("period2 write",    1, ch_addr(2, 3), 32'hDEADBEEF, 4'hF, 0, 32'h0, 0));
        vecs.push_back(mk("period2 read",     0, ch_addr(2, 3), 32'h0, 4'hF, 1, 32'hDEADBEEF, 0));
        vecs.push_back(mk("ch2 w1c on match", 1, ch_addr(2, 2), 32'h4, 4'hF, 0, 32'h0, 0));
        vecs.push_back(mk("ch2 pending kept", 0, ch_addr(2, 2), 32'h0, 4'hF, 1, 32'h4, 0));
        vecs.push_back(mk("ch3 periodic",     1, ch_addr(3, 2), 32'h3, 4'hF, 0, 32'h0, 0));
        vecs.push_back(mk("ch3 period0 pend", 0, ch_addr(3, 2), 32'h0, 4'hF, 1, 32'h7, 0));
        vecs.push_back(mk("cmp3 write",       1, ch_addr(3, 0), 32'h0, 4'hF, 0, 32'h0, 0));
        vecs.push_back(mk("cmp3 write wins",  0, ch_addr(3, 2), 32'h0, 4'hF, 1, 32'h3, 0));
        vecs.push_back(mk("ch3 re-pend",      0, ch_addr(3, 2), 32'h0, 4'hF, 1, 32'h7, 0));
        vecs.push_back(mk("bad channel rd",   0, 32'h8040, 32'h0, 4'hF, 1, 32'h0, 1));
        vecs.push_back(mk("unmapped rd",      0, 32'h1234, 32'h0, 4'hF, 1, 32'h0, 1));
        vecs.push_back(mk("unmapped wr",      1, 32'h1234, 32'h5, 4'hF, 1, 32'h0, 1));
        vecs.push_back(mk("region c000 rd",   0, 32'hC000, 32'h0, 4'hF, 1, 32'h0, 1));
        vecs.push_back(mk("channel 15 rd",    0, 32'h80F8, 32'h0, 4'hF, 1, 32'h0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            bus(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].b, rd_v, er_v);
            if (vecs[i].chk_rd) chk(vecs[i].name, {32'd0, rd_v}, {32'd0, vecs[i].exp_rd});
            chk({vecs[i].name, " err"}, {63'd0, er_v}, {63'd0, vecs[i].exp_err});
        end
        // ch0 matched once mtime went huge; ch3 keeps re-asserting
        chk("intr after table", {60'd0, intr}, 64'h9);

        // channel 1 periodic, period 50
        wr(A_PSC, 32'd0);
        wr(A_MLO, 32'd0);
        wr(A_MHI, 32'd0);
        wr(ch_addr(1, 3), 32'd50);
        wr(ch_addr(1, 0), 32'd50);
        wr(ch_addr(1, 1), 32'd0);
        wr(ch_addr(1, 2), 32'd3);
        wr(A_CTRL, 32'd1);
        repeat (50) @(negedge clk);
        rd_chk("ch1 before 50", ch_addr(1, 2), 32'd3);
        rd_chk("ch1 match 50", ch_addr(1, 2), 32'd7);
        chk("ch1 intr", {63'd0, intr[1]}, 64'd1);
        wr(ch_addr(1, 2), 32'd7);
        rd_chk("ch1 w1c", ch_addr(1, 2), 32'd3);
        rd_chk("ch1 cmp 100", ch_addr(1, 0), 32'd100);
        repeat (45) @(negedge clk);
        rd_chk("ch1 before 100", ch_addr(1, 2), 32'd3);
        rd_chk("ch1 match 100", ch_addr(1, 2), 32'd7);
        repeat (57) @(negedge clk);
        rd_chk("ch1 cmp 200", ch_addr(1, 0), 32'd200);
        rd_chk("ch1 cmp hi", ch_addr(1, 1), 32'd0);
        rd_chk("ch1 pending 150", ch_addr(1, 2), 32'd7);

        // coherent 64-bit read across a low-word carry
        wr(A_CTRL, 32'd0);
        wr(A_MLO, 32'hFFFF_FFFE);
        wr(A_MHI, 32'd0);
        wr(A_CTRL, 32'd1);
        rd_chk("carry lo", A_MLO, 32'hFFFF_FFFE);
        repeat (4) @(negedge clk);
`ifdef RV_TIMER_NCH_SNAPSHOT_EN
        exp_hi = 32'd0;
`else
        exp_hi = 32'd1;
`endif
        rd_chk("carry hi", A_MHI, exp_hi);

        // asynchronous reset with a response in flight
        req = 1'b1; we = 1'b0; addr = A_CTRL; be = 4'hF;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset rvalid", {63'd0, rvalid}, 64'd0);
        chk("midreset intr", {60'd0, intr}, 64'd0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("post reset ctrl", A_CTRL, 32'd0);
        rd_chk("post reset mtime", A_MLO, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_timer_nch.md
Name: rv_timer_nch

Overview:
- Memory-mapped, multi-channel RISC-V-style machine timer.
- One shared 64-bit mtime counter with a programmable prescaler and a global enable.
- NumChannels independent 64-bit comparators, each with an interrupt enable, a sticky pending flag and an optional periodic auto-reload.
- Sits on the same single-cycle req / rvalid data bus as the other system peripherals, decoded into a 64 KiB window.

Parameters:
- DataWidth, 32, bus data width; must be 32 (elaboration-time assertion).
- AddressWidth, 32, bus address width.
- NumChannels, 4, number of comparator channels; legal range 1..16.
- PrescaleWidth, 16, width of the prescaler counter and register.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- timer_req_i  in  1  bus request
- timer_addr_i  in  AddressWidth  byte address; only bits [15:0] are decoded
- timer_we_i  in  1  write enable
- timer_be_i  in  DataWidth/8  byte enables
- timer_wdata_i  in  DataWidth  write data
- timer_rvalid_o  out  1  response valid
- timer_rdata_o  out  DataWidth  read data
- timer_err_o  out  1  response error
- timer_intr_o  out  NumChannels  per-channel interrupt, equal to pending & ie

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: all registers 0; timer_rvalid_o = 0; timer_intr_o = 0; timer_err_o = 0. rdata/err flops carry no reset, and their values are valid only while rvalid is high.
- Register map (offset within the 64 KiB window):
  - 0x0000 CTRL: bit0 = EN (counter runs).
  - 0x0004 PRESCALE: bits [PrescaleWidth-1:0].
  - 0x4000 MTIME_LO; 0x4004 MTIME_HI.
  - Channel c at 0x8000 + 16*c:
    - +0x0 CMP_LO; +0x4 CMP_HI.
    - +0x8 CH_CTRL: bit0 IE, bit1 PERIODIC, bit2 PENDING (read; write 1 to clear).
    - +0xC PERIOD (32 bits).
- Bus response:
  - rvalid = 1 exactly one cycle after any req (read or write).
  - rdata / err are captured on a req cycle.
  - Reads return the current register value; reserved bits read 0.
  - err = 1, rdata = 0 on an unmapped offset or a channel index >= NumChannels.
  - Writes with timer_be_i not all-ones are ignored: no state change, no error.
- Prescaler:
  - psc_cnt increments each cycle while EN = 1.
  - When psc_cnt == PRESCALE: generate a tick and set psc_cnt to 0.
  - PRESCALE = 0 gives a tick every cycle.
  - Clearing EN holds both mtime and psc_cnt.
  - A write to PRESCALE resets psc_cnt to 0.
- mtime:
  - On a tick, mtime = mtime + 1, wrapping modulo 2^64.
  - A bus write to MTIME_LO/HI replaces that half in the same cycle and overrides the increment of that half; the other half takes its incremented value.
- Channel match: compare mtime_q >= cmp_q, unsigned 64-bit, evaluated every cycle.
  - One-shot mode (PERIODIC = 0): match sets PENDING. PENDING stays set until CMP_LO/HI is written or until a 1 is written to CH_CTRL bit2.
  - Periodic mode (PERIODIC = 1): on a match cycle, PENDING is set and cmp = cmp + zero-extended PERIOD (wraps modulo 2^64). With PERIOD = 0 the comparator stays matched and PENDING re-asserts every cycle.
- Simultaneous events:
  - CMP write in the same cycle as a match: the write wins, PENDING is cleared, no reload.
  - W1C in the same cycle as a match: PENDING stays set (set wins).
- Interrupt output: timer_intr_o[c] = PENDING[c] & IE[c], registered. It asserts one cycle after the match condition, with no combinational path from the bus.
- Reset mid-operation: an asynchronous reset clears everything immediately, including any in-flight response.

Optional Feature:
- Macro: RV_TIMER_NCH_SNAPSHOT_EN.
- When defined:
  - A read of MTIME_LO latches mtime[63:32] into a shadow register.
  - A subsequent read of MTIME_HI returns the shadow, giving a coherent 64-bit read.
  - The shadow resets to 0.
- When undefined: MTIME_HI returns live mtime[63:32] and no shadow flop exists.

Test Plan:
- Reset, then EN = 1, PRESCALE = 0, 10 cycles, read MTIME_LO -> ~10 (exact value per bench cycle count); rvalid one cycle after req; err = 0.
- PRESCALE = 3, EN = 1, 40 cycles -> mtime advances by 10. Clear EN -> mtime frozen over 20 cycles.
- Ch0: CMP = 100, IE = 1, one-shot -> intr_o[0] rises one cycle after mtime reaches 100 and stays high. Write CMP_LO = 500 -> intr_o[0] drops.
- Ch1: PERIODIC = 1, PERIOD = 50, CMP = 50 -> PENDING sets at 50, 100, 150; CMP reads 200 after the third match. W1C clears PENDING between matches.
- Accesses to ch index NumChannels and to offset 0x1234 -> err = 1, rdata = 0. Write with be = 4'b0011 to CMP_LO -> value unchanged, err = 0.
- Snapshot build: set mtime = 0x0000_0000_FFFF_FFFE, read LO, wait 4 cycles, read HI -> HI = 0x0. Non-snapshot build -> HI = 0x1.
